// File: rtl/crtc_lite.sv
// rtl/crtc_lite.sv - 6845-style CRT controller subset: timing counters, syncs, display enable and address generation.
module crtc_lite #(
    parameter bit HSW0_IS_16 = 1'b1,
    parameter bit VSW0_IS_16 = 1'b1
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        CCLK_EN,
    input  logic        WE,
    input  logic        RS,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic [13:0] MA,
    output logic [4:0]  RA,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DISPEN
);

    typedef enum logic {ACTIVE, ADJUST} state_t;

    logic [4:0]  ar;
    logic [7:0]  r0, r1, r2, r3, r13;
    logic [6:0]  r4, r6, r7;
    logic [4:0]  r5, r9;
    logic [5:0]  r12;

    logic [7:0]  hcc;
    logic [4:0]  rc;
    logic [6:0]  vcc;
    state_t      state;
    logic [13:0] rowbase, nextbase;
    logic [4:0]  hs_left, vs_left;
    logic        vs_done;

    logic        line_end, frame_end;
    logic [7:0]  hcc_next;
    logic [4:0]  rc_next;
    logic [6:0]  vcc_next;
    state_t      state_next;
    logic [4:0]  hsw, vsw;
    logic        hsync_trig, vsync_trig, dispen_next;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ar  <= '0;
            r0  <= '0; r1 <= '0; r2 <= '0; r3 <= '0;
            r4  <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
            r9  <= '0; r12 <= '0; r13 <= '0;
        end else if (WE) begin
            if (!RS) begin
                ar <= D_IN[4:0];
            end else begin
                case (ar)
                    5'd0:  r0  <= D_IN;
                    5'd1:  r1  <= D_IN;
                    5'd2:  r2  <= D_IN;
                    5'd3:  r3  <= D_IN;
                    5'd4:  r4  <= D_IN[6:0];
                    5'd5:  r5  <= D_IN[4:0];
                    5'd6:  r6  <= D_IN[6:0];
                    5'd7:  r7  <= D_IN[6:0];
                    5'd9:  r9  <= D_IN[4:0];
                    5'd12: r12 <= D_IN[5:0];
                    5'd13: r13 <= D_IN;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (ar)
            5'd12:   D_OUT = {2'b00, r12};
            5'd13:   D_OUT = r13;
            default: D_OUT = 8'h00;
        endcase
    end

    // Next-state of the counters; HCC wraps naturally at 255 if R0 was moved below it.
    always_comb begin
        line_end   = (hcc == r0);
        hcc_next   = line_end ? 8'd0 : hcc + 8'd1;
        rc_next    = rc;
        vcc_next   = vcc;
        state_next = state;
        frame_end  = 1'b0;
        if (line_end) begin
            if (state == ADJUST) begin
                if (rc == r5 - 5'd1) frame_end = 1'b1;
                else                 rc_next   = rc + 5'd1;
            end else if (rc == r9) begin
                if (vcc == r4) begin
                    if (r5 == 5'd0) begin
                        frame_end = 1'b1;
                    end else begin
                        state_next = ADJUST;
                        rc_next    = 5'd0;
                    end
                end else begin
                    rc_next  = 5'd0;
                    vcc_next = vcc + 7'd1;
                end
            end else begin
                rc_next = rc + 5'd1;
            end
            if (frame_end) begin
                rc_next    = 5'd0;
                vcc_next   = 7'd0;
                state_next = ACTIVE;
            end
        end
    end

    always_comb begin
        hsw = (r3[3:0] == 4'd0) ? (HSW0_IS_16 ? 5'd16 : 5'd0) : {1'b0, r3[3:0]};
        vsw = (r3[7:4] == 4'd0) ? (VSW0_IS_16 ? 5'd16 : 5'd0) : {1'b0, r3[7:4]};
        hsync_trig  = (hcc_next == r2) && (hsw != 5'd0);
        vsync_trig  = line_end && (vcc_next == r7) && (rc_next == 5'd0) &&
                      (state_next == ACTIVE) && !vs_done && (vsw != 5'd0);
        dispen_next = (hcc_next < r1) && (vcc_next < r6) && (state_next == ACTIVE);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hcc      <= '0;
            rc       <= '0;
            vcc      <= '0;
            state    <= ACTIVE;
            rowbase  <= '0;
            nextbase <= '0;
            hs_left  <= '0;
            vs_left  <= '0;
            vs_done  <= 1'b0;
            HSYNC    <= 1'b0;
            VSYNC    <= 1'b0;
            DISPEN   <= 1'b0;
        end else if (CCLK_EN) begin
            hcc    <= hcc_next;
            rc     <= rc_next;
            vcc    <= vcc_next;
            state  <= state_next;
            DISPEN <= dispen_next;

            if (hcc == r1 && rc == r9)
                nextbase <= rowbase + {6'd0, r1};
            if (frame_end)
                rowbase <= {r12, r13};
            else if (line_end && rc == r9 && state == ACTIVE)
                rowbase <= nextbase;

            // Pulse counters run independently of the line wrap.
            if (hsync_trig) begin
                HSYNC   <= 1'b1;
                hs_left <= hsw;
            end else if (HSYNC) begin
                if (hs_left == 5'd1) HSYNC <= 1'b0;
                else                 hs_left <= hs_left - 5'd1;
            end

            if (line_end) begin
                if (frame_end) vs_done <= 1'b0;
                if (vsync_trig) begin
                    VSYNC   <= 1'b1;
                    vs_left <= vsw;
                    vs_done <= 1'b1;
                end else if (VSYNC) begin
                    if (vs_left == 5'd1) VSYNC <= 1'b0;
                    else                 vs_left <= vs_left - 5'd1;
                end
            end
        end
    end

    assign MA = rowbase + {6'd0, hcc};
    assign RA = rc;

endmodule

// File: tb/tb_crtc_lite.sv
// tb/tb_crtc_lite.sv - directed self-checking bench for crtc_lite using CPC default timing.
module tb_crtc_lite;

    logic        clk = 1'b0;
    logic        RESET_N, CCLK_EN, WE, RS;
    logic [7:0]  D_IN, D_OUT;
    logic [13:0] MA;
    logic [4:0]  RA;
    logic        HSYNC, VSYNC, DISPEN;

    int vectors = 0;
    int miscompares = 0;

    crtc_lite dut (
        .clk(clk), .RESET_N(RESET_N), .CCLK_EN(CCLK_EN), .WE(WE), .RS(RS),
        .D_IN(D_IN), .D_OUT(D_OUT), .MA(MA), .RA(RA),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DISPEN(DISPEN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        CCLK_EN = 1'b1;
        @(posedge clk); #1;
        CCLK_EN = 1'b0;
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        RS = rs; D_IN = d; WE = 1'b1;
        @(posedge clk); #1;
        WE = 1'b0;
    endtask

    task automatic wreg(input logic [7:0] a, input logic [7:0] d);
        wr(1'b0, a);
        wr(1'b1, d);
    endtask

    int hs_hi, hs_rise, hs_first, hs_last, ds_hi, vs_hi, vs_rise_at, n, w;
    logic ph, pv, adj_bad;
    logic [13:0] ma_vs;

    initial begin
        RESET_N = 1'b0; CCLK_EN = 1'b0; WE = 1'b0; RS = 1'b0; D_IN = 8'h00;
        #3;
        chk("reset_outputs", {MA, RA, HSYNC, VSYNC, DISPEN, D_OUT}, 32'h0);
        repeat (3) @(posedge clk);
        #1 RESET_N = 1'b1;

        wreg(0, 63); wreg(1, 40); wreg(2, 46); wreg(3, 8'h8E); wreg(4, 38);
        wreg(5, 0);  wreg(6, 25); wreg(7, 30); wreg(9, 7);
        wreg(12, 8'hFF);
        chk("r12_width", D_OUT, 8'h3F);
        wr(1'b1, 8'h30);
        chk("r12_read", D_OUT, 8'h30);
        wreg(13, 8'h5A);
        chk("r13_read", D_OUT, 8'h5A);
        wr(1'b1, 8'h00);
        wr(1'b0, 8'd4);
        chk("dout_other_ar", D_OUT, 8'h00);
        chk("ma_before_cclk", MA, 14'h0);

        // Frame 0: starts from the reset row base of 0.
        step();
        chk("ma_first", MA, 14'd1);
        chk("dispen_first", DISPEN, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("ma_hold_no_cclk", MA, 14'd1);

        hs_hi = 0; hs_rise = 0; hs_first = 0; hs_last = 0; vs_hi = 0; vs_rise_at = 0;
        ds_hi = 1; ph = HSYNC; pv = VSYNC; ma_vs = '0;
        for (int p = 2; p <= 19968; p++) begin
            step();
            if (HSYNC) hs_hi++;
            if (HSYNC && !ph) begin
                hs_rise++;
                hs_last = p;
                if (hs_rise == 1) hs_first = p;
            end
            if (DISPEN) ds_hi++;
            if (VSYNC) vs_hi++;
            if (VSYNC && !pv) begin
                vs_rise_at = p;
                ma_vs = MA;
                chk("ra_at_vsync", RA, 5'd0);
            end
            if (p == 512) chk("ma_row1_frame0", MA, 14'h0028);
            ph = HSYNC; pv = VSYNC;
        end
        chk("hsync_first_rise", hs_first, 46);
        chk("hsync_last_rise", hs_last, 19950);
        chk("hsync_rises", hs_rise, 312);
        chk("hsync_high_total", hs_hi, 312 * 14);
        chk("dispen_high_total", ds_hi, 8000);
        chk("vsync_rise_pos", vs_rise_at, 15360);
        chk("ma_at_vsync", ma_vs, 14'h04B0);
        chk("vsync_high_total", vs_hi, 512);
        chk("ma_frame_start", MA, 14'h3000);
        chk("ra_frame_start", RA, 5'd0);
        repeat (512) step();
        chk("ma_row1_start", MA, 14'h3028);

        // Frame 1 with two adjust lines, R5 written mid-frame.
        wreg(5, 2);
        adj_bad = 1'b0;
        for (int o = 513; o <= 20096; o++) begin
            step();
            if (o >= 19968 && o < 20096) adj_bad = adj_bad | DISPEN | VSYNC;
            if (o == 20032) chk("ra_adjust_line1", RA, 5'd1);
        end
        chk("adjust_quiet", adj_bad, 1'b0);
        chk("ma_after_adjust", MA, 14'h3000);
        chk("ra_after_adjust", RA, 5'd0);

        // Zero width fields select 16, and unimplemented addresses are ignored.
        wreg(5, 0);
        wreg(3, 8'h00);
        wreg(14, 8'h55);
        chk("dout_ar14", D_OUT, 8'h00);
        n = 0;
        while (!HSYNC && n < 100) begin step(); n++; end
        chk("hsync16_found", HSYNC, 1'b1);
        w = 0;
        while (HSYNC && w < 40) begin step(); w++; end
        chk("hsync16_width", w, 16);
        n = 0;
        while (!VSYNC && n < 20000) begin step(); n++; end
        chk("vsync16_found", VSYNC, 1'b1);
        w = 0;
        while (VSYNC && w < 3000) begin step(); w++; end
        chk("vsync16_width", w, 16 * 64);

        // Asynchronous reset while HSYNC is high.
        wr(1'b0, 8'd12);
        chk("dout_r12_pre_reset", D_OUT, 8'h30);
        n = 0;
        while (!HSYNC && n < 100) begin step(); n++; end
        chk("hsync_pre_reset", HSYNC, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_reset_outputs", {MA, RA, HSYNC, VSYNC, DISPEN, D_OUT}, 32'h0);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        wreg(0, 63);
        chk("ma_after_reset", MA, 14'h0);
        step();
        chk("ma_restart", MA, 14'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
